// File: rtl/prog_clk_divider_if.sv
// Handshake and status bundle for prog_clk_divider.
// The master drives enable and ratio load; the slave returns the divided clock, tick, phase and load status.
interface prog_clk_divider_if #(
    parameter int unsigned DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div_ratio;
    logic             div_load;
    logic             div_ack;
    logic             div_err;
    logic             clk_out;
    logic             tick;
    logic [DIV_W-1:0] cnt;

    modport master (
        output en, div_ratio, div_load,
        input  div_ack, div_err, clk_out, tick, cnt
    );

    modport slave (
        input  en, div_ratio, div_load,
        output div_ack, div_err, clk_out, tick, cnt
    );
endinterface

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with glitch-free ratio changes at period boundaries.
// Optional macro ODD_DUTY50_EN adds a negedge flop so odd ratios get an exact 50% duty cycle.
module prog_clk_divider #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 8
) (
    input  logic              clk,
    input  logic              res,
    prog_clk_divider_if.slave bus
);
    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             p_q, p_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             wrap;
    logic             apply;
    logic             load_ok;
    logic             load_bad;
    logic [DIV_W-1:0] n_eff;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q      <= DEF_N - ONE;
            n_q        <= DEF_N;
            pend_val_q <= DEF_N;
            pend_q     <= 1'b0;
            p_q        <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            p_q        <= p_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    // A pending ratio takes effect on the wrap edge, so the new period's duty uses it from phase 0.
    always_comb begin
        load_ok    = bus.div_load && (bus.div_ratio >= TWO);
        load_bad   = bus.div_load && (bus.div_ratio < TWO);
        wrap       = bus.en && (cnt_q == (n_q - ONE));
        apply      = wrap && pend_q;
        n_eff      = apply ? pend_val_q : n_q;

        cnt_d      = cnt_q;
        n_d        = n_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        p_d        = p_q;
        tick_d     = 1'b0;
        ack_d      = 1'b0;
        err_d      = err_q;

        if (bus.en) begin
            cnt_d  = wrap ? '0 : cnt_q + ONE;
            p_d    = (cnt_d < (n_eff >> 1));
            tick_d = wrap;
        end

        if (apply) begin
            n_d    = pend_val_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end

        // A load on the wrap edge re-arms pending, so it lands on the following wrap.
        if (load_ok) begin
            pend_d     = 1'b1;
            pend_val_d = bus.div_ratio;
            err_d      = 1'b0;
        end else if (load_bad) begin
            err_d = 1'b1;
        end
    end

`ifdef ODD_DUTY50_EN
    logic p_neg_q;

    // Half-cycle delayed copy stretches the high phase by half a clk for odd ratios.
    always_ff @(negedge clk or posedge res) begin
        if (res) begin
            p_neg_q <= 1'b0;
        end else begin
            p_neg_q <= p_q;
        end
    end

    assign bus.clk_out = n_q[0] ? (p_q | p_neg_q) : p_q;
`else
    assign bus.clk_out = p_q;
`endif

    assign bus.cnt     = cnt_q;
    assign bus.tick    = tick_q;
    assign bus.div_ack = ack_q;
    assign bus.div_err = err_q;
endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed self-checking bench for prog_clk_divider (default build, odd duty floor/ceil).
module tb_prog_clk_divider;
    localparam int unsigned DIV_W = 8;

    logic clk;
    logic res;
    int   checks;
    int   passes;

    prog_clk_divider_if #(.DIV_W(DIV_W)) bus ();

    prog_clk_divider #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(8)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_chk(input string tag, input int ecnt, input int eclk,
                            input int etick, input int eack);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".cnt"},     32'(bus.cnt),     32'(ecnt));
        chk({tag, ".clk_out"}, 32'(bus.clk_out), 32'(eclk));
        chk({tag, ".tick"},    32'(bus.tick),    32'(etick));
        chk({tag, ".ack"},     32'(bus.div_ack), 32'(eack));
    endtask

    // Steady counting under ratio n: high while phase < n/2, tick at phase 0, no ack.
    task automatic run(input string tag, input int n, input int ph_start, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            int ph;
            ph = (ph_start + k) % n;
            step_chk(tag, ph, (ph < n / 2) ? 1 : 0, (ph == 0) ? 1 : 0, 0);
        end
    endtask

    initial begin
        checks        = 0;
        passes        = 0;
        res           = 1'b1;
        bus.en        = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_ratio = '0;

        // Reset values
        #3;
        chk("rst.cnt",     32'(bus.cnt),     32'd7);
        chk("rst.clk_out", 32'(bus.clk_out), 32'd0);
        chk("rst.tick",    32'(bus.tick),    32'd0);
        chk("rst.ack",     32'(bus.div_ack), 32'd0);
        chk("rst.err",     32'(bus.div_err), 32'd0);
        @(negedge clk);
        res    = 1'b0;
        bus.en = 1'b1;

        // 1: default N=8, first enabled edge wraps
        run("t1", 8, 0, 20);

        // 2: load 5 at cnt=3, applied at next wrap
        bus.div_load  = 1'b1;
        bus.div_ratio = 8'd5;
        step_chk("t2.load", 4, 0, 0, 0);
        bus.div_load  = 1'b0;
        run("t2.pre", 8, 5, 3);
        step_chk("t2.apply", 0, 1, 1, 1);
        run("t2.n5", 5, 1, 9);

        // 3: invalid load sets err; valid load on a wrap edge defers one period
        bus.div_load  = 1'b1;
        bus.div_ratio = 8'd1;
        step_chk("t3.bad", 0, 1, 1, 0);
        chk("t3.err_set", 32'(bus.div_err), 32'd1);
        bus.div_load  = 1'b0;
        run("t3.n5a", 5, 1, 4);
        chk("t3.err_hold", 32'(bus.div_err), 32'd1);
        bus.div_load  = 1'b1;
        bus.div_ratio = 8'd4;
        step_chk("t3.wrapload", 0, 1, 1, 0);
        chk("t3.err_clr", 32'(bus.div_err), 32'd0);
        bus.div_load  = 1'b0;
        run("t3.n5b", 5, 1, 4);
        step_chk("t3.apply", 0, 1, 1, 1);
        run("t3.n4", 4, 1, 5);

        // 4: freeze at phase 1 for 3 cycles, then resume
        bus.en = 1'b0;
        step_chk("t4.hold0", 1, 1, 0, 0);
        step_chk("t4.hold1", 1, 1, 0, 0);
        step_chk("t4.hold2", 1, 1, 0, 0);
        bus.en = 1'b1;
        run("t4.resume", 4, 2, 4);

        // 5: back-to-back loads 6 then 3, single ack, last wins
        bus.div_load  = 1'b1;
        bus.div_ratio = 8'd6;
        step_chk("t5.ld6", 2, 0, 0, 0);
        bus.div_ratio = 8'd3;
        step_chk("t5.ld3", 3, 0, 0, 0);
        bus.div_load  = 1'b0;
        step_chk("t5.apply", 0, 1, 1, 1);
        run("t5.n3", 3, 1, 6);

        // 6: async reset between edges discards pending load
        bus.div_load  = 1'b1;
        bus.div_ratio = 8'd7;
        step_chk("t6.ld7", 1, 0, 0, 0);
        bus.div_load  = 1'b0;
        #2 res = 1'b1;
        #1;
        chk("t6.rst.cnt",     32'(bus.cnt),     32'd7);
        chk("t6.rst.clk_out", 32'(bus.clk_out), 32'd0);
        chk("t6.rst.tick",    32'(bus.tick),    32'd0);
        chk("t6.rst.ack",     32'(bus.div_ack), 32'd0);
        chk("t6.rst.err",     32'(bus.div_err), 32'd0);
        #1 res = 1'b0;
        step_chk("t6.first", 0, 1, 1, 0);
        run("t6.n8", 8, 1, 8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
